// File: rtl/lsu_het_arbiter_pkg.sv
// Shared types and request-id helpers for the heterogeneous LSU arbiter.
package lsu_het_arbiter_pkg;

    localparam int unsigned LSU_ID_W = 32;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DRAINED
    } lsu_het_arb_state_t;

    // Build the LSU id as {requester index, requester tag}; tag occupies the low tag_w bits.
    function automatic logic [LSU_ID_W-1:0] pack_req_id(
        input logic [LSU_ID_W-1:0] idx,
        input logic [LSU_ID_W-1:0] tag,
        input int unsigned         tag_w
    );
        logic [LSU_ID_W-1:0] mask;
        mask = (LSU_ID_W'(1) << tag_w) - LSU_ID_W'(1);
        return (idx << tag_w) | (tag & mask);
    endfunction

    // Recover the requester index from an LSU id.
    function automatic logic [LSU_ID_W-1:0] unpack_req_idx(
        input logic [LSU_ID_W-1:0] id,
        input int unsigned         tag_w
    );
        return id >> tag_w;
    endfunction

endpackage

// File: rtl/lsu_het_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searching upward from an internal
// pointer; the pointer moves past the winner when update_en is high.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         update_en,
    output logic [N-1:0] grant
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic             found;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        int unsigned j;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && request[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                winner   = IDX_W'(j);
            end
        end
    end

    // Advance the pointer to the slot after the winner; hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (update_en && found) begin
            ptr <= (winner == IDX_W'(N - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/lsu_het_arbiter.sv
// Shares one LSU request port among NUM_REQ accelerators, routes responses and
// rollback errors back by the index embedded in the id, tracks per-requester
// in-flight counts and provides a drain/quiesce handshake.
module lsu_het_arbiter
    import lsu_het_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned REQ_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned THREAD_NUMB   = 8,
    parameter int unsigned THREAD_IDX_W  = $clog2(THREAD_NUMB),
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned WORDS_PERLINE = DATA_WIDTH / 32,
    parameter int unsigned TAG_W         = 32 - REQ_IDX_W,
    parameter int unsigned MAX_OUT       = 8,
    parameter int unsigned CNT_W         = $clog2(MAX_OUT + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     rq_valid,
    output logic [NUM_REQ-1:0]                     rq_ready,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]          rq_tag,
    input  logic [NUM_REQ-1:0][THREAD_IDX_W-1:0]   rq_thread_id,
    input  logic [NUM_REQ-1:0][7:0]                rq_op,
    input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  rq_address,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     rq_data,
    input  logic [NUM_REQ-1:0][WORDS_PERLINE-1:0]  rq_hw_lane_mask,
    output logic                                   lsu_req_valid,
    output logic [31:0]                            lsu_req_id,
    output logic [THREAD_IDX_W-1:0]                lsu_req_thread_id,
    output logic [7:0]                             lsu_req_op,
    output logic [ADDRESS_WIDTH-1:0]               lsu_req_address,
    output logic [DATA_WIDTH-1:0]                  lsu_req_data,
    output logic [WORDS_PERLINE-1:0]               lsu_req_hw_lane_mask,
    input  logic [THREAD_NUMB-1:0]                 lsu_almost_full,
    input  logic [THREAD_NUMB-1:0]                 lsu_no_load_store_pending,
    input  logic                                   lsu_rsp_valid,
    input  logic [31:0]                            lsu_rsp_id,
    input  logic                                   lsu_rsp_miss,
    input  logic [DATA_WIDTH-1:0]                  lsu_rsp_cache_line,
    input  logic                                   lsu_err_valid,
    input  logic [31:0]                            lsu_err_id,
    input  logic [THREAD_IDX_W-1:0]                lsu_err_thread_id,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [TAG_W-1:0]                       rsp_tag,
    output logic                                   rsp_miss,
    output logic [DATA_WIDTH-1:0]                  rsp_data,
    output logic [NUM_REQ-1:0]                     err_valid,
    output logic [TAG_W-1:0]                       err_tag,
    output logic [THREAD_IDX_W-1:0]                err_thread_id,
    input  logic                                   drain_req,
    output logic                                   drain_done,
    output logic [NUM_REQ-1:0][CNT_W-1:0]          outstanding_cnt
);

    lsu_het_arb_state_t         state;
    logic [NUM_REQ-1:0]         eligible;
    logic [NUM_REQ-1:0]         grant;
    logic [REQ_IDX_W-1:0]       grant_idx;
    logic [31:0]                rsp_idx;
    logic [31:0]                err_idx;
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_next;
    logic                       quiet;

    // Requester may compete only while running, not being drained, and its thread and credit allow.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = reset && (state == RUN) && !drain_req && rq_valid[i]
                        && !lsu_almost_full[rq_thread_id[i]]
                        && (outstanding_cnt[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk      (clk),
        .reset    (reset),
        .request  (eligible),
        .update_en(|grant),
        .grant    (grant)
    );

    assign rq_ready = grant;

    // Encode the one-hot grant into the requester index.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = REQ_IDX_W'(i);
        end
    end

    assign rsp_idx       = unpack_req_idx(lsu_rsp_id, TAG_W);
    assign err_idx       = unpack_req_idx(lsu_err_id, TAG_W);
    assign rsp_tag       = lsu_rsp_id[TAG_W-1:0];
    assign rsp_miss      = lsu_rsp_miss;
    assign rsp_data      = lsu_rsp_cache_line;
    assign err_tag       = lsu_err_id[TAG_W-1:0];
    assign err_thread_id = lsu_err_thread_id;

    // Steer response and error strobes to the owning requester; out-of-range indices strobe nothing.
    always_comb begin
        rsp_valid = '0;
        err_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = lsu_rsp_valid && (rsp_idx == i);
            err_valid[i] = lsu_err_valid && (err_idx == i);
        end
    end

    // Register the granted request toward the LSU; payload holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsu_req_valid        <= 1'b0;
            lsu_req_id           <= '0;
            lsu_req_thread_id    <= '0;
            lsu_req_op           <= '0;
            lsu_req_address      <= '0;
            lsu_req_data         <= '0;
            lsu_req_hw_lane_mask <= '0;
        end else begin
            lsu_req_valid <= |grant;
            if (|grant) begin
                lsu_req_id           <= pack_req_id(32'(grant_idx), 32'(rq_tag[grant_idx]), TAG_W);
                lsu_req_thread_id    <= rq_thread_id[grant_idx];
                lsu_req_op           <= rq_op[grant_idx];
                lsu_req_address      <= rq_address[grant_idx];
                lsu_req_data         <= rq_data[grant_idx];
                lsu_req_hw_lane_mask <= rq_hw_lane_mask[grant_idx];
            end
        end
    end

    // Net counter change (+grant, -response, -error), floored at zero instead of wrapping.
    always_comb begin
        int sum;
        cnt_next = '0;
        sum      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = int'(outstanding_cnt[i]) + int'(grant[i])
                - int'(rsp_valid[i]) - int'(err_valid[i]);
            cnt_next[i] = (sum < 0) ? '0 : CNT_W'(sum);
        end
    end

    // Per-requester in-flight counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_cnt <= '0;
        end else begin
            outstanding_cnt <= cnt_next;
        end
    end

    assign quiet = (outstanding_cnt == '0) && !lsu_req_valid && (&lsu_no_load_store_pending);

    // Drain sequencer with registered drain_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state <= RUN;
                    end else if (quiet) begin
                        state      <= DRAINED;
                        drain_done <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_het_arbiter.md
Name: lsu_het_arbiter

Overview:
- Shares one heterogeneous-accelerator LSU port among NUM_REQ accelerator requesters.
- Does round-robin arbitration gated by per-thread backpressure, and tags each issued request with its requester index.
- Routes responses and rollback errors back to the owning requester.
- Tracks outstanding requests per requester and provides a drain/quiesce sequence for reconfiguration or flush.

Parameters:
- NUM_REQ, 4, number of accelerator requesters.
- REQ_IDX_W, $clog2(NUM_REQ), requester index width (minimum 1).
- THREAD_NUMB, 8, LSU thread count.
- THREAD_IDX_W, $clog2(THREAD_NUMB), thread id width.
- ADDRESS_WIDTH, 32, address width.
- DATA_WIDTH, 512, cache line width.
- WORDS_PERLINE, DATA_WIDTH/32, lanes per line.
- TAG_W, 32-REQ_IDX_W, requester tag width.
- MAX_OUT, 8, maximum outstanding requests per requester.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rq_valid  in  NUM_REQ  request valid per requester
- rq_ready  out  NUM_REQ  request accepted (grant)
- rq_tag  in  NUM_REQ x TAG_W  requester tag
- rq_thread_id  in  NUM_REQ x THREAD_IDX_W  target LSU thread
- rq_op  in  NUM_REQ x 8  LSU op
- rq_address  in  NUM_REQ x ADDRESS_WIDTH  address
- rq_data  in  NUM_REQ x DATA_WIDTH  store data
- rq_hw_lane_mask  in  NUM_REQ x WORDS_PERLINE  lane mask
- lsu_req_valid, lsu_req_id(32), lsu_req_thread_id, lsu_req_op(8), lsu_req_address, lsu_req_data, lsu_req_hw_lane_mask  out  -  registered request to LSU
- lsu_almost_full  in  THREAD_NUMB  per-thread LSU backpressure
- lsu_no_load_store_pending  in  THREAD_NUMB  per-thread idle from LSU
- lsu_rsp_valid  in  1  LSU response valid
- lsu_rsp_id  in  32  LSU response id
- lsu_rsp_miss  in  1  LSU response miss flag
- lsu_rsp_cache_line  in  DATA_WIDTH  LSU response data
- lsu_err_valid  in  1  LSU rollback error valid
- lsu_err_id  in  32  LSU rollback error id
- lsu_err_thread_id  in  THREAD_IDX_W  LSU rollback error thread
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_tag  out  TAG_W  broadcast response tag
- rsp_miss  out  1  broadcast miss flag
- rsp_data  out  DATA_WIDTH  broadcast response data
- err_valid  out  NUM_REQ  one-hot rollback strobe
- err_tag  out  TAG_W  broadcast rollback tag
- err_thread_id  out  THREAD_IDX_W  broadcast rollback thread
- drain_req  in  1  level request to quiesce
- drain_done  out  1  high while quiesced
- outstanding_cnt  out  NUM_REQ x $clog2(MAX_OUT+1)  per-requester in-flight count (debug)

Behaviour:
- Reset (reset low, asynchronous) clears:
  - all lsu_req_* outputs, rq_ready, drain_done and every counter to 0;
  - RR pointer to 0;
  - FSM to RUN.
- Eligibility of requester i: rq_valid[i], !lsu_almost_full[rq_thread_id[i]], outstanding_cnt[i] < MAX_OUT, and FSM == RUN.
- Grant:
  - Combinational round-robin among eligible requesters, starting at the RR pointer. At most one rq_ready per cycle.
  - Handshake completes when rq_valid & rq_ready. rq_ready is not asserted for ineligible requesters.
  - After a grant to i, the RR pointer becomes (i+1) mod NUM_REQ. With no grant the pointer holds.
- Issue (1-cycle latency): on a grant, the next cycle has:
  - lsu_req_valid=1;
  - lsu_req_id = {i[REQ_IDX_W-1:0], rq_tag[i]};
  - other fields copied from requester i.
  - With no grant, lsu_req_valid=0 and the data fields hold.
- Response routing (combinational, 0 latency):
  - lsu_rsp_valid sets rsp_valid[lsu_rsp_id[31:TAG_W]].
  - rsp_tag = lsu_rsp_id[TAG_W-1:0]; miss and data pass through.
  - An index >= NUM_REQ strobes nothing.
- Error routing: identical scheme driven from lsu_err_valid / lsu_err_id onto err_valid / err_tag; err_thread_id passes through.
- Each issued request terminates exactly once, by either a response (hit or miss) or an error.
- Counters:
  - outstanding_cnt[i] += grant to i (counted at grant);
  - outstanding_cnt[i] -= response to i, and -= error to i.
  - Net change is in the range -2..+1 within a cycle.
  - Decrement at 0 is ignored and does not wrap (sticky underflow is not tracked).
  - At MAX_OUT the requester is ineligible.
- Drain FSM:
  - RUN: drain_req=1 goes to DRAIN, and no grants are issued from that cycle.
  - DRAIN: moves to DRAINED when all counters are 0, lsu_req_valid=0 and lsu_no_load_store_pending is all ones.
  - DRAINED: drain_done=1. drain_req=0 returns to RUN next cycle, with drain_done=0.
  - drain_req dropping while in DRAIN returns to RUN.
  - Responses and errors continue to be routed in all states.
- Reset mid-operation: in-flight LSU responses after reset may target counters at 0; the underflow rule applies.

Decomposition:
- Package entries (npu_defines):
  - lsu_het_arb_state_t enum {RUN, DRAIN, DRAINED};
  - helper function packing/unpacking {req_idx, tag} into the 32-bit id.
- Sub-module rr_arbiter: parameter N; inputs request[N] and update_en; output one-hot grant; owns its own pointer. The generic codebase arbiter is reused if present.

Test Plan:
- Single requester 2: rq_tag=0x5A, thread 3 -> lsu_req_valid one cycle later with lsu_req_id=0x8000005A (NUM_REQ=4); response id 0x8000005A -> rsp_valid=4'b0100, rsp_tag=0x5A.
- All 4 requesters valid continuously -> grants in order 0,1,2,3,0 with exactly one rq_ready per cycle.
- lsu_almost_full[3]=1, requester 0 targets thread 3 and requester 1 targets thread 0 -> only requester 1 granted until almost_full drops.
- Requester 0 issues 8 with no responses -> outstanding_cnt[0]=8 and rq_ready[0] stays 0; one response returns -> count=7 and the next grant is allowed; a same-cycle grant+response+error -> net -1.
- Error id 0x40000011 on thread 5 -> err_valid=4'b0010, err_tag=0x11, err_thread_id=5, outstanding_cnt[1] decremented.
- drain_req=1 with 3 outstanding -> no grants, drain_done=0 until all responses arrive and no_load_store_pending=0xFF, then drain_done=1; drain_req=0 -> grants resume next cycle; assert reset mid-DRAIN -> RUN with all outputs 0.
